// File: rtl/ex_mem_reg_if.sv
// Execute-to-memory pipeline bundle.
// Carries the _e side into the register and the _m side out.
interface ex_mem_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      valid_e;
  logic                      reg_write_e;
  logic [1:0]                result_src_e;
  logic                      mem_write_e;
  logic                      mem_read_e;
  logic [1:0]                type_control_e;
  logic                      sign_ext_flag_e;
  logic [DATA_WIDTH-1:0]     alu_result_e;
  logic [DATA_WIDTH-1:0]     write_data_e;
  logic [REG_ADDR_WIDTH-1:0] rd_e;
  logic [DATA_WIDTH-1:0]     pc_plus4_e;

  logic                      valid_m;
  logic                      reg_write_m;
  logic [1:0]                result_src_m;
  logic                      mem_write_m;
  logic                      mem_read_m;
  logic [1:0]                type_control_m;
  logic                      sign_ext_flag_m;
  logic [DATA_WIDTH-1:0]     alu_result_m;
  logic [DATA_WIDTH-1:0]     write_data_m;
  logic [REG_ADDR_WIDTH-1:0] rd_m;
  logic [DATA_WIDTH-1:0]     pc_plus4_m;
  logic                      misaligned_m;

  modport master (
    output valid_e, reg_write_e, result_src_e,
    output mem_write_e, mem_read_e, type_control_e,
    output sign_ext_flag_e, alu_result_e,
    output write_data_e, rd_e, pc_plus4_e,
    input  valid_m, reg_write_m, result_src_m,
    input  mem_write_m, mem_read_m, type_control_m,
    input  sign_ext_flag_m, alu_result_m,
    input  write_data_m, rd_m, pc_plus4_m,
    input  misaligned_m
  );

  modport slave (
    input  valid_e, reg_write_e, result_src_e,
    input  mem_write_e, mem_read_e, type_control_e,
    input  sign_ext_flag_e, alu_result_e,
    input  write_data_e, rd_e, pc_plus4_e,
    output valid_m, reg_write_m, result_src_m,
    output mem_write_m, mem_read_m, type_control_m,
    output sign_ext_flag_m, alu_result_m,
    output write_data_m, rd_m, pc_plus4_m,
    output misaligned_m
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: stall hold, deferred flush,
// alignment qualification and a saturating stall counter.
module ex_mem_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  ex_mem_reg_if.slave bus,
  output logic [31:0] stall_count
);

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [1:0]                result_src;
    logic                      mem_write;
    logic                      mem_read;
    logic [1:0]                type_control;
    logic                      sign_ext_flag;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic                      misaligned;
  } payload_t;

  payload_t    payload_d, payload_q;
  payload_t    incoming;
  logic        pending_flush_d, pending_flush_q;
  logic [31:0] stall_count_d, stall_count_q;
  logic        addr_bad;
  logic        misaligned;

  always_comb begin
    addr_bad = 1'b0;
    case (bus.type_control_e)
      2'b01:   addr_bad = bus.alu_result_e[0];
      2'b10:   addr_bad = 1'b0;
      default: addr_bad = |bus.alu_result_e[1:0];
    endcase
    misaligned = addr_bad &
                 (bus.mem_write_e | bus.mem_read_e);
  end

  // A misaligned access never reaches memory or the regfile.
  always_comb begin
    incoming               = '0;
    incoming.valid         = 1'b1;
    incoming.reg_write     = bus.reg_write_e &
                             ~(misaligned & bus.mem_read_e);
    incoming.result_src    = bus.result_src_e;
    incoming.mem_write     = bus.mem_write_e & ~misaligned;
    incoming.mem_read      = bus.mem_read_e & ~misaligned;
    incoming.type_control  = bus.type_control_e;
    incoming.sign_ext_flag = bus.sign_ext_flag_e;
    incoming.alu_result    = bus.alu_result_e;
    incoming.write_data    = bus.write_data_e;
    incoming.rd            = bus.rd_e;
    incoming.pc_plus4      = bus.pc_plus4_e;
    incoming.misaligned    = misaligned;
  end

  always_comb begin
    payload_d       = payload_q;
    pending_flush_d = pending_flush_q;
    if (stall) begin
      if (flush) pending_flush_d = 1'b1;
    end else if (flush || pending_flush_q || !bus.valid_e) begin
      payload_d       = '0;
      pending_flush_d = 1'b0;
    end else begin
      payload_d       = incoming;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != 32'hFFFF_FFFF)
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload_q       <= '0;
      pending_flush_q <= 1'b0;
      stall_count_q   <= '0;
    end else begin
      payload_q       <= payload_d;
      pending_flush_q <= pending_flush_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign bus.valid_m         = payload_q.valid;
  assign bus.reg_write_m     = payload_q.reg_write;
  assign bus.result_src_m    = payload_q.result_src;
  assign bus.mem_write_m     = payload_q.mem_write;
  assign bus.mem_read_m      = payload_q.mem_read;
  assign bus.type_control_m  = payload_q.type_control;
  assign bus.sign_ext_flag_m = payload_q.sign_ext_flag;
  assign bus.alu_result_m    = payload_q.alu_result;
  assign bus.write_data_m    = payload_q.write_data;
  assign bus.rd_m            = payload_q.rd;
  assign bus.pc_plus4_m      = payload_q.pc_plus4;
  assign bus.misaligned_m    = payload_q.misaligned;
  assign stall_count         = stall_count_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed scoreboard bench for ex_mem_reg.
// Stimulus pushes expectations; a monitor pops after each edge.
module tb_ex_mem_reg;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        mr;
    logic [1:0]  tc;
    logic        sx;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mis;
  } m_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] stall_count;
  logic        dummy;

  ex_mem_reg_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  ex_mem_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .bus         (bus),
    .stall_count (stall_count)
  );

  m_t          exp_q[$];
  logic [31:0] cnt_q[$];
  string       name_q[$];
  int          n_cmp;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic m_t mk(
    input logic v, input logic rw, input logic [1:0] rs,
    input logic mw, input logic mr, input logic [1:0] tc,
    input logic sx, input logic [31:0] alu,
    input logic [31:0] wd, input logic [4:0] rd,
    input logic [31:0] pc, input logic mis);
    return {v, rw, rs, mw, mr, tc, sx, alu, wd, rd, pc, mis};
  endfunction

  task automatic step(
    input string nm, input m_t e,
    input logic r, input logic st, input logic fl,
    input m_t ex, input logic [31:0] cnt);
    @(negedge clk);
    rst   = r;
    stall = st;
    flush = fl;
    {bus.valid_e, bus.reg_write_e, bus.result_src_e,
     bus.mem_write_e, bus.mem_read_e, bus.type_control_e,
     bus.sign_ext_flag_e, bus.alu_result_e,
     bus.write_data_e, bus.rd_e, bus.pc_plus4_e, dummy} = e;
    exp_q.push_back(ex);
    cnt_q.push_back(cnt);
    name_q.push_back(nm);
  endtask

  // Monitor: one expectation per edge, sampled 2ns after it.
  initial begin
    m_t          act;
    m_t          ex;
    logic [31:0] ce;
    string       nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        ce  = cnt_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.valid_m, bus.reg_write_m, bus.result_src_m,
               bus.mem_write_m, bus.mem_read_m,
               bus.type_control_m, bus.sign_ext_flag_m,
               bus.alu_result_m, bus.write_data_m, bus.rd_m,
               bus.pc_plus4_m, bus.misaligned_m};
        n_cmp++;
        if (act !== ex || stall_count !== ce) begin
          n_fail++;
          $display("FAIL %s: got m=%h cnt=%h want m=%h cnt=%h",
                   nm, act, stall_count, ex, ce);
        end
      end
    end
  end

  initial begin
    m_t z, r0, a, st, b, c, d, e, g, h, x;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    dummy  = 1'b0;
    z  = '0;
    r0 = mk(1, 1, 2'b11, 1, 1, 2'b10, 1, 32'hFFFF_FFFF,
            32'h5555, 5'd31, 32'h8, 0);
    a  = mk(1, 1, 2'b01, 0, 0, 2'b00, 0, 32'h100,
            32'hAAAA, 5'd5, 32'h104, 0);
    st = mk(1, 0, 2'b00, 1, 0, 2'b00, 0, 32'h40,
            32'hDEAD_BEEF, 5'd0, 32'h44, 0);
    b  = mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 32'h55, 0, 5'd7, 32'h50, 0);
    c  = mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 32'h66, 0, 5'd8, 32'h54, 0);
    d  = mk(1, 1, 2'b10, 0, 0, 2'b00, 0, 32'h77, 0, 5'd9, 32'h58, 0);
    e  = mk(1, 0, 2'b00, 1, 0, 2'b10, 0, 32'h91, 32'hFF, 5'd0,
            32'h5C, 0);
    g  = mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 32'h300, 0, 5'd12,
            32'h220, 0);
    h  = mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 32'h400, 0, 5'd13,
            32'h224, 0);

    step("reset", r0, 1, 1, 1, z, 32'd0);
    step("load_a", a, 0, 0, 0, a, 32'd0);
    step("store_w", st, 0, 0, 0, st, 32'd0);
    for (int i = 0; i < 4; i++) begin
      x = mk(1, 1, 2'b01, 0, 1, 2'b00, 0, 32'h80 + 32'(i * 4),
             32'(i), 5'(i + 1), 32'h300, 0);
      step("stall_hold", x, 0, 1, 0, st, 32'(i + 1));
    end

    step("load_b", b, 0, 0, 0, b, 32'd4);
    step("dflush_s1", c, 0, 1, 0, b, 32'd5);
    step("dflush_s2", c, 0, 1, 1, b, 32'd6);
    step("dflush_s3", c, 0, 1, 0, b, 32'd7);
    step("dflush_bub", c, 0, 0, 0, z, 32'd7);
    step("dflush_next", c, 0, 0, 0, c, 32'd7);

    step("rflush_s1", d, 0, 1, 1, c, 32'd8);
    step("rflush_s2", d, 0, 1, 0, c, 32'd9);
    step("rflush_s3", d, 0, 1, 1, c, 32'd10);
    step("rflush_bub", d, 0, 0, 0, z, 32'd10);
    step("rflush_next", d, 0, 0, 0, d, 32'd10);
    step("byte_st_ok", e, 0, 0, 0, e, 32'd10);

    step("mis_word_ld",
         mk(1, 1, 2'b01, 0, 1, 2'b00, 1, 32'h102, 32'h11, 5'd9,
            32'h200, 0), 0, 0, 0,
         mk(1, 0, 2'b01, 0, 0, 2'b00, 1, 32'h102, 32'h11, 5'd9,
            32'h200, 1), 32'd10);
    step("mis_half_st",
         mk(1, 0, 2'b00, 1, 0, 2'b01, 0, 32'h103, 32'h22, 5'd0,
            32'h204, 0), 0, 0, 0,
         mk(1, 0, 2'b00, 0, 0, 2'b01, 0, 32'h103, 32'h22, 5'd0,
            32'h204, 1), 32'd10);
    x = mk(1, 0, 2'b00, 1, 0, 2'b10, 0, 32'h103, 32'h33, 5'd0,
           32'h208, 0);
    step("byte_st_103", x, 0, 0, 0, x, 32'd10);
    x = mk(1, 1, 2'b01, 0, 1, 2'b01, 1, 32'h102, 0, 5'd3,
           32'h20C, 0);
    step("half_ld_ok", x, 0, 0, 0, x, 32'd10);
    step("mis_rsv_ld",
         mk(1, 1, 2'b01, 0, 1, 2'b11, 0, 32'h101, 0, 5'd4,
            32'h210, 0), 0, 0, 0,
         mk(1, 0, 2'b01, 0, 0, 2'b11, 0, 32'h101, 0, 5'd4,
            32'h210, 1), 32'd10);
    x = mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 32'h103, 0, 5'd6,
           32'h214, 0);
    step("nomem_odd", x, 0, 0, 0, x, 32'd10);

    step("flush_only",
         mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 32'h1, 0, 5'd1,
            32'h218, 0), 0, 0, 1, z, 32'd10);
    step("invalid_st",
         mk(0, 0, 2'b00, 1, 0, 2'b00, 0, 32'h40, 32'h9, 5'd0,
            32'h21C, 0), 0, 0, 0, z, 32'd10);

    step("load_g", g, 0, 0, 0, g, 32'd10);
    step("pend_set", h, 0, 1, 1, g, 32'd11);
    step("rst_midstall", h, 1, 1, 0, z, 32'd0);
    step("post_rst", h, 0, 0, 0, h, 32'd0);

    @(negedge clk);
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    step("sat_1", e, 0, 1, 0, h, 32'hFFFF_FFFF);
    step("sat_2", e, 0, 1, 0, h, 32'hFFFF_FFFF);
    step("sat_3", e, 0, 1, 0, h, 32'hFFFF_FFFF);
    step("sat_free", h, 0, 0, 0, h, 32'hFFFF_FFFF);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
